// File: rtl/pow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pow_pkg
// Description : Shared constants for the pow_arbiter slice: default operand
//               width and the state encodings of the arbiter and the engine.
// Revision    : 1.0 - initial release
// ============================================================================
package pow_pkg;

    // Default operand/result width.
    localparam int unsigned C_W_DEFAULT = 32;

    // Arbiter state encoding.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t C_ARB_IDLE  = 2'd0;
    localparam arb_state_t C_ARB_GRANT = 2'd1;
    localparam arb_state_t C_ARB_RUN   = 2'd2;
    localparam arb_state_t C_ARB_DONE  = 2'd3;

    // Engine state encoding.
    typedef logic [1:0] eng_state_t;
    localparam eng_state_t C_ENG_IDLE = 2'd0;
    localparam eng_state_t C_ENG_RUN  = 2'd1;
    localparam eng_state_t C_ENG_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pow_engine.sv
`default_nettype none
// ============================================================================
// Module      : pow_engine
// Description : Modular exponentiation base^exp mod 2^W using right-to-left
//               square-and-multiply, one exponent bit per cycle. Operands are
//               loaded on start; done pulses for one cycle with result valid.
// Revision    : 1.0 - initial release
// ============================================================================
module pow_engine
    import pow_pkg::*;
#(
    parameter int W = C_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] base,
    input  logic [W-1:0] exp,
    output logic         done,
    output logic [W-1:0] result
);

    eng_state_t   r_state;
    eng_state_t   w_state_nxt;
    logic [W-1:0] r_acc;   // running product of selected powers
    logic [W-1:0] r_sq;    // base^(2^k) for the current bit k
    logic [W-1:0] r_exp;   // remaining exponent bits, consumed LSB first

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ENG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: run until every exponent bit is consumed, then report.
    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        case (r_state)
            C_ENG_IDLE: begin
                if (start) begin
                    w_state_nxt = C_ENG_RUN;
                end
            end
            C_ENG_RUN: begin
                if (r_exp == '0) begin
                    w_state_nxt = C_ENG_DONE;
                end
            end
            C_ENG_DONE: begin
                done        = 1'b1;
                w_state_nxt = C_ENG_IDLE;
            end
            default: begin
                w_state_nxt = C_ENG_IDLE;
            end
        endcase
    end

    // Datapath: load on start, then one square-and-multiply step per cycle.
    // Products are assigned to W-bit registers, so only the low W bits survive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_sq  <= '0;
            r_exp <= '0;
        end else if (r_state == C_ENG_IDLE && start) begin
            r_acc <= W'(1);
            r_sq  <= base;
            r_exp <= exp;
        end else if (r_state == C_ENG_RUN && r_exp != '0) begin
            if (r_exp[0]) begin
                r_acc <= r_acc * r_sq;
            end
            r_sq  <= r_sq * r_sq;
            r_exp <= r_exp >> 1;
        end
    end

    assign result = r_acc;

endmodule
`default_nettype wire

// File: rtl/pow_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pow_arbiter
// Description : Round-robin arbiter sharing one pow_engine between two
//               requesters. IDLE -> GRANT -> RUN -> DONE, operands latched in
//               GRANT, one-cycle done pulse to the served requester.
// Revision    : 1.0 - initial release
// ============================================================================
module pow_arbiter
    import pow_pkg::*;
#(
    parameter int W = C_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] base0,
    input  logic [W-1:0] base1,
    input  logic [W-1:0] exp0,
    input  logic [W-1:0] exp1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] res,
    output logic         busy
);

    arb_state_t   r_state;
    arb_state_t   w_state_nxt;
    logic         w_pick;      // port that would win if arbitration happened now
    logic         r_winner;    // port owning the engine (0 or 1)
    logic         r_last;      // port served most recently
    logic [W-1:0] r_base;
    logic [W-1:0] r_exp;
    logic         r_start;
    logic [W-1:0] r_res;
    logic         w_eng_done;
    logic [W-1:0] w_eng_result;

    // On a tie the port not served last wins; a lone request always wins.
    assign w_pick = (req0 && req1) ? ~r_last : req1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the arbitration sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ARB_IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt = C_ARB_GRANT;
                end
            end
            C_ARB_GRANT: begin
                w_state_nxt = C_ARB_RUN;
            end
            C_ARB_RUN: begin
                if (w_eng_done) begin
                    w_state_nxt = C_ARB_DONE;
                end
            end
            C_ARB_DONE: begin
                w_state_nxt = C_ARB_IDLE;
            end
            default: begin
                w_state_nxt = C_ARB_IDLE;
            end
        endcase
    end

    // Winner, operand capture, engine start, result capture and RR pointer.
    // start is registered so the engine sees the already-latched operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_winner <= 1'b0;
            r_last   <= 1'b1;
            r_base   <= '0;
            r_exp    <= '0;
            r_start  <= 1'b0;
            r_res    <= '0;
        end else begin
            r_start <= (r_state == C_ARB_GRANT);
            if (r_state == C_ARB_IDLE && (req0 || req1)) begin
                r_winner <= w_pick;
            end
            if (r_state == C_ARB_GRANT) begin
                r_base <= r_winner ? base1 : base0;
                r_exp  <= r_winner ? exp1  : exp0;
            end
            if (r_state == C_ARB_RUN && w_eng_done) begin
                r_res <= w_eng_result;
            end
            if (r_state == C_ARB_DONE) begin
                r_last <= r_winner;
            end
        end
    end

    pow_engine #(
        .W (W)
    ) u_engine (
        .clk    (clk),
        .rst    (rst),
        .start  (r_start),
        .base   (r_base),
        .exp    (r_exp),
        .done   (w_eng_done),
        .result (w_eng_result)
    );

    assign busy  = (r_state != C_ARB_IDLE);
    assign gnt0  = busy && !r_winner;
    assign gnt1  = busy &&  r_winner;
    assign done0 = (r_state == C_ARB_DONE) && !r_winner;
    assign done1 = (r_state == C_ARB_DONE) &&  r_winner;
    assign res   = (r_state == C_ARB_DONE) ? r_res : '0;

endmodule
`default_nettype wire

// File: tb/tb_pow_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pow_arbiter
// Description : Scoreboard bench for pow_arbiter. Drivers push the expected
//               (port, result) of every issued operation; a monitor pops and
//               compares on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pow_arbiter;

    localparam int W       = 32;
    localparam int C_LAT   = 2 * W + 10;   // per-operation cycle budget

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] base0, base1, exp0, exp1;
    logic         gnt0, gnt1, done0, done1, busy;
    logic [W-1:0] res;

    typedef struct {
        int           port;
        logic [W-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   last     = 1;   // model of the port served most recently

    always #5 clk = ~clk;

    pow_arbiter #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .base0 (base0),
        .base1 (base1),
        .exp0  (exp0),
        .exp1  (exp1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done0 (done0),
        .done1 (done1),
        .res   (res),
        .busy  (busy)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: repeated multiplication in W-bit arithmetic. Huge exponents
    // are only used with bases 0, 1 and all-ones, whose powers are closed-form.
    function automatic logic [W-1:0] model_pow(logic [W-1:0] b, logic [W-1:0] e);
        logic [W-1:0] r;
        r = W'(1);
        if (e > 32'd4096) begin
            if (b == '0) return '0;
            if (b == W'(1)) return W'(1);
            return e[0] ? b : W'(1);
        end
        for (int unsigned i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
            if (done0 || done1) begin
                check("done_onehot", 64'(done0 & done1), 64'd0);
                check("done_owner_gnt", 64'(done0 ? gnt0 : gnt1), 64'd1);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_done: got done0=%0b done1=%0b res=0x%0h, expected no done",
                             done0, done1, res);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("done_port", 64'(done1 ? 1 : 0), 64'(x.port));
                    check("result", 64'(res), 64'(x.val));
                end
            end
        end
    end

    task automatic wait_dones(int n, int budget, string tag);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done0 || done1) seen++;
        end
        n_checks++;
        if (seen != n) begin
            n_fails++;
            $display("FAIL %s_timeout: got %0d done pulses, expected %0d within %0d cycles",
                     tag, seen, n, budget);
        end
    endtask

    // One request on port p; request dropped and operands scrambled after grant.
    task automatic single(int p, logic [W-1:0] b, logic [W-1:0] e);
        exp_t x;
        x.port = p;
        x.val  = model_pow(b, e);
        sb.push_back(x);
        last = p;
        if (p == 0) begin base0 = b; exp0 = e; req0 = 1'b1; end
        else        begin base1 = b; exp1 = e; req1 = 1'b1; end
        @(negedge clk);
        check("grant_latency", 64'(p == 0 ? gnt0 : gnt1), 64'd1);
        check("other_gnt_low", 64'(p == 0 ? gnt1 : gnt0), 64'd0);
        check("busy_in_grant", 64'(busy), 64'd1);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        base0 = $urandom; base1 = $urandom; exp0 = $urandom; exp1 = $urandom;
        // engine bound 2W+4 plus RUN->DONE, counted from the first RUN cycle
        wait_dones(1, 2 * W + 6, "single");
        @(negedge clk);
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    // Both requests held continuously for n operations with fixed operands.
    task automatic both(int n, logic [W-1:0] b0, logic [W-1:0] e0,
                        logic [W-1:0] b1, logic [W-1:0] e1);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            x.port = (last == 0) ? 1 : 0;
            x.val  = (x.port == 0) ? model_pow(b0, e0) : model_pow(b1, e1);
            sb.push_back(x);
            last = x.port;
        end
        base0 = b0; exp0 = e0; base1 = b1; exp1 = e1;
        req0 = 1'b1; req1 = 1'b1;
        wait_dones(n, n * C_LAT, "both");
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("idle_after_both", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] b, e;
        int           mode;

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        base0 = '0; base1 = '0; exp0 = '0; exp1 = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({gnt0, gnt1, done0, done1, busy, res}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Simultaneous requests after reset: port 0 first, then port 1.
        both(2, 32'd2, 32'd10, 32'd5, 32'd3);
        single(0, 32'd3, 32'd5);
        both(4, 32'd7, 32'd9, 32'd11, 32'd13);

        // exp = 0, all-ones base, wrap-around and long exponents.
        single(0, 32'd7, 32'd0);
        single(1, 32'd0, 32'd0);
        single(0, 32'hFFFF_FFFF, 32'd1);
        single(1, 32'h0001_0000, 32'd2);
        single(0, 32'd3, 32'd40);
        single(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        single(0, 32'd1, 32'hFFFF_FFFF);
        single(1, 32'd0, 32'hFFFF_FFFE);

        // A request raised and dropped while busy never gets served.
        single(0, 32'd9, 32'd7);
        begin
            exp_t x;
            x.port = 0;
            x.val  = model_pow(32'd5, 32'd200);
            sb.push_back(x);
            last = 0;
            base0 = 32'd5; exp0 = 32'd200; req0 = 1'b1;
            @(negedge clk);
            @(negedge clk);
            req0 = 1'b0;
            req1 = 1'b1;
            repeat (3) @(negedge clk);
            req1 = 1'b0;
            wait_dones(1, C_LAT, "drop_before_grant");
            repeat (6) @(negedge clk);
        end

        // Reset during RUN: no done, outputs cleared, pointer back to port 0.
        base0 = 32'd3; exp0 = 32'hFFFF_FFFF; req0 = 1'b1;
        repeat (6) @(negedge clk);
        req0 = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        check("reset_mid_run", 64'({gnt0, gnt1, done0, done1, busy, res}), 64'd0);
        rst  = 1'b0;
        last = 1;
        repeat (2 * W + 8) @(negedge clk);
        check("quiet_after_reset", 64'({gnt0, gnt1, done0, done1, busy, res}), 64'd0);
        both(2, 32'd6, 32'd4, 32'd2, 32'd31);

        // Randomized traffic.
        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(0, 2);
            b = $urandom;
            if ($urandom_range(0, 1) == 0) b = 32'($urandom_range(0, 20));
            e = 32'($urandom_range(0, 300));
            if (mode == 2) both(2, b, e, $urandom, 32'($urandom_range(0, 300)));
            else           single(mode, b, e);
        end

        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
